// File: rtl/serial_add_pkg.sv
// Shared constants and state encoding for the serial adder sequencer.
package serial_add_pkg;

  localparam int DEF_WIDTH   = 23;  // operand and result width
  localparam int DEF_CNT_W   = 5;   // bit/latency counter width
  localparam int DEF_ADD_LAT = 25;  // load edge to sum-sample edge

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RX_A = 3'd1,
    RX_B = 3'd2,
    LOAD = 3'd3,
    WAIT = 3'd4,
    HOLD = 3'd5
  } state_e;

endpackage

// File: rtl/serial_shift_rx.sv
// Serial receiver: bit counter plus indexed write into operand word A or B.
// clear restarts at bit 0; a bit arriving with clear is written as bit 0.
module serial_shift_rx
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             sel,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic [WIDTH-1:0] word_a,
  output logic [WIDTH-1:0] word_b,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] idx;

  assign idx  = clear ? '0 : cnt_q;
  assign done = bit_valid && (idx == CNT_W'(WIDTH - 1));

  // Write the incoming bit at the current index and advance the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      // NOTE: the operand words are ordinary flops feeding ports, not a RAM, so they take the reset.
      word_a <= '0;
      word_b <= '0;
    end else if (bit_valid) begin
      // NOTE: non-blocking assignments so every flop updates from pre-edge values.
      if (sel) word_b[idx] <= bit_in;
      else     word_a[idx] <= bit_in;
      cnt_q <= done ? '0 : idx + CNT_W'(1);
    end else if (clear) begin
      cnt_q <= '0;
    end
  end

endmodule

// File: rtl/serial_add_sequencer.sv
// Control stage for the serial adder: receives A then B LSB-first, strobes the
// adder loads, waits out its fixed latency, and holds the sum on a valid/ready port.
module serial_add_sequencer
  import serial_add_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int ADD_LAT = DEF_ADD_LAT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             la,
  output logic             lb,
  output logic             si,
  input  logic [WIDTH-1:0] sum_in,
  output logic [WIDTH-1:0] res_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy,
  output logic             overrun
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] lat_q, lat_d;
  logic             rx_active;
  logic             accept_start;
  logic             rx_valid;
  logic             rx_sel;
  logic             rx_done;
  logic             capture;
  logic             drop;

  // A new frame is accepted from IDLE or as a restart while receiving.
  assign rx_active    = (state_q == RX_A) || (state_q == RX_B);
  assign accept_start = frame_start && ((state_q == IDLE) || rx_active);
  assign rx_valid     = bit_valid && (rx_active || accept_start);
  assign rx_sel       = (state_q == RX_B) && !frame_start;
  assign si           = 1'b0;

  serial_shift_rx #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (accept_start),
    .sel       (rx_sel),
    .bit_valid (rx_valid),
    .bit_in    (bit_in),
    .word_a    (A),
    .word_b    (B),
    .done      (rx_done)
  );

  // Next-state, latency count and event decode.
  always_comb begin
    // NOTE: defaults first so no branch leaves a signal unassigned and infers a latch.
    state_d = state_q;
    lat_d   = lat_q;
    capture = 1'b0;
    drop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_start)    state_d = RX_A;
        else if (bit_valid) drop = 1'b1;
      end
      RX_A: begin
        if (frame_start)  state_d = RX_A;
        else if (rx_done) state_d = RX_B;
      end
      RX_B: begin
        if (frame_start)  state_d = RX_A;
        else if (rx_done) state_d = LOAD;
      end
      LOAD: begin
        drop    = frame_start || bit_valid;
        state_d = WAIT;
        lat_d   = '0;
      end
      WAIT: begin
        drop = frame_start || bit_valid;
        if (lat_q == CNT_W'(ADD_LAT - 1)) begin
          capture = 1'b1;
          state_d = HOLD;
        end else begin
          lat_d = lat_q + CNT_W'(1);
        end
      end
      HOLD: begin
        drop = frame_start || bit_valid;
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lat_q     <= '0;
      la        <= 1'b0;
      lb        <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      la        <= (state_d == LOAD);
      lb        <= (state_d == LOAD);
      busy      <= (state_d != IDLE);
      overrun   <= drop;
      res_valid <= (state_d == HOLD);
      if (capture) res_data <= sum_in;
    end
  end

endmodule
